// File: rtl/pop_multichannel_sequencer.sv
// Programmable N-channel pulse sequencer: free-running cycle counter with per-channel start/stop compares.
// Optional burst-length support is enabled by defining POP_BURST_EN (adds the burst_len input).
module pop_multichannel_sequencer #(
  parameter int WIDTH      = 16,
  parameter int NCH        = 4,
  parameter int ADDR_W     = 5,
  parameter int DEF_PERIOD = 50000
) (
  input  logic              clk_2M5,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              run,
  input  logic              stop,
  input  logic              abort,
  input  logic              oneshot,
`ifdef POP_BURST_EN
  input  logic [WIDTH-1:0]  burst_len,
`endif
  output logic [NCH-1:0]    pulse_out,
  output logic              cycle_start,
  output logic              busy,
  output logic [WIDTH-1:0]  cycle_cnt
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  start_sh_q [NCH];
  logic [WIDTH-1:0]  start_sh_d [NCH];
  logic [WIDTH-1:0]  stop_sh_q  [NCH];
  logic [WIDTH-1:0]  stop_sh_d  [NCH];
  logic [WIDTH-1:0]  start_lv_q [NCH];
  logic [WIDTH-1:0]  start_lv_d [NCH];
  logic [WIDTH-1:0]  stop_lv_q  [NCH];
  logic [WIDTH-1:0]  stop_lv_d  [NCH];
  logic [WIDTH-1:0]  period_sh_q, period_sh_d;
  logic [WIDTH-1:0]  period_lv_q, period_lv_d;
  logic              oneshot_q, oneshot_d;
  logic              stop_latch_q, stop_latch_d;
  logic [WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [NCH-1:0]    pulse_out_q, pulse_out_d;
  logic              cycle_start_q, cycle_start_d;
`ifdef POP_BURST_EN
  logic [WIDTH-1:0]  burst_q, burst_d;
`endif

  logic [WIDTH-1:0]  period_eff;
  logic              terminal;
  logic              burst_done;

  // Periods of 0 or 1 run as a 2-count cycle so the terminal is never also count 0.
  assign period_eff = (period_lv_q < WIDTH'(2)) ? WIDTH'(2) : period_lv_q;
  assign terminal   = (count_q == (period_eff - WIDTH'(1)));

`ifdef POP_BURST_EN
  assign burst_done = (burst_q != '0) && ((cycle_cnt_q + WIDTH'(1)) == burst_q);
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    start_sh_d  = start_sh_q;
    stop_sh_d   = stop_sh_q;
    period_sh_d = period_sh_q;
    if (wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_addr == ADDR_W'(2 * i))     start_sh_d[i] = wr_data;
        if (wr_addr == ADDR_W'(2 * i + 1)) stop_sh_d[i]  = wr_data;
      end
      if (wr_addr == ADDR_W'(2 * NCH)) period_sh_d = wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    start_lv_d    = start_lv_q;
    stop_lv_d     = stop_lv_q;
    period_lv_d   = period_lv_q;
    oneshot_d     = oneshot_q;
    stop_latch_d  = stop_latch_q;
    cycle_cnt_d   = cycle_cnt_q;
    pulse_out_d   = '0;
    cycle_start_d = 1'b0;
`ifdef POP_BURST_EN
    burst_d       = burst_q;
`endif
    if (abort) begin
      state_d      = ST_IDLE;
      count_d      = '0;
      stop_latch_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Live registers track the shadows (including this cycle's write) while idle.
          count_d      = '0;
          start_lv_d   = start_sh_d;
          stop_lv_d    = stop_sh_d;
          period_lv_d  = period_sh_d;
          stop_latch_d = 1'b0;
          if (run) begin
            state_d      = ST_RUN;
            oneshot_d    = oneshot;
            cycle_cnt_d  = '0;
            stop_latch_d = stop;
`ifdef POP_BURST_EN
            burst_d      = burst_len;
`endif
          end
        end
        ST_RUN: begin
          cycle_start_d = (count_q == '0);
          for (int i = 0; i < NCH; i++) begin
            pulse_out_d[i] = (start_lv_q[i] <= count_q) && (count_q < stop_lv_q[i]);
          end
          stop_latch_d = stop_latch_q | stop;
          if (terminal) begin
            start_lv_d  = start_sh_d;
            stop_lv_d   = stop_sh_d;
            period_lv_d = period_sh_d;
            cycle_cnt_d = cycle_cnt_q + WIDTH'(1);
            count_d     = '0;
            if (oneshot_q || stop_latch_q || stop || burst_done) begin
              state_d      = ST_IDLE;
              stop_latch_d = 1'b0;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2M5) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      for (int i = 0; i < NCH; i++) begin
        start_sh_q[i] <= '0;
        stop_sh_q[i]  <= '0;
        start_lv_q[i] <= '0;
        stop_lv_q[i]  <= '0;
      end
      period_sh_q   <= WIDTH'(DEF_PERIOD);
      period_lv_q   <= WIDTH'(DEF_PERIOD);
      oneshot_q     <= 1'b0;
      stop_latch_q  <= 1'b0;
      cycle_cnt_q   <= '0;
      pulse_out_q   <= '0;
      cycle_start_q <= 1'b0;
`ifdef POP_BURST_EN
      burst_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      start_sh_q    <= start_sh_d;
      stop_sh_q     <= stop_sh_d;
      start_lv_q    <= start_lv_d;
      stop_lv_q     <= stop_lv_d;
      period_sh_q   <= period_sh_d;
      period_lv_q   <= period_lv_d;
      oneshot_q     <= oneshot_d;
      stop_latch_q  <= stop_latch_d;
      cycle_cnt_q   <= cycle_cnt_d;
      pulse_out_q   <= pulse_out_d;
      cycle_start_q <= cycle_start_d;
`ifdef POP_BURST_EN
      burst_q       <= burst_d;
`endif
    end
  end

  assign pulse_out   = pulse_out_q;
  assign cycle_start = cycle_start_q;
  assign busy        = (state_q == ST_RUN);
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_pop_multichannel_sequencer.sv
// Testbench for pop_multichannel_sequencer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the sequencer rules.
module tb_pop_multichannel_sequencer;

  localparam int WIDTH      = 16;
  localparam int NCH        = 4;
  localparam int ADDR_W     = 5;
  localparam int DEF_PERIOD = 50000;

  logic              clk_2M5 = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              run = 1'b0;
  logic              stop = 1'b0;
  logic              abort = 1'b0;
  logic              oneshot = 1'b0;
`ifdef POP_BURST_EN
  logic [WIDTH-1:0]  burst_len = '0;
`endif
  logic [NCH-1:0]    pulse_out;
  logic              cycle_start;
  logic              busy;
  logic [WIDTH-1:0]  cycle_cnt;

  always #200 clk_2M5 = ~clk_2M5;

  pop_multichannel_sequencer #(
    .WIDTH(WIDTH), .NCH(NCH), .ADDR_W(ADDR_W), .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .clk_2M5    (clk_2M5),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .run        (run),
    .stop       (stop),
    .abort      (abort),
    .oneshot    (oneshot),
`ifdef POP_BURST_EN
    .burst_len  (burst_len),
`endif
    .pulse_out  (pulse_out),
    .cycle_start(cycle_start),
    .busy       (busy),
    .cycle_cnt  (cycle_cnt)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: integers and arrays, one entry per spec-visible quantity.
  bit             m_running = 0;
  int             m_count = 0;
  int             m_start_sh [NCH];
  int             m_stop_sh  [NCH];
  int             m_start_lv [NCH];
  int             m_stop_lv  [NCH];
  int             m_period_sh = DEF_PERIOD;
  int             m_period_lv = DEF_PERIOD;
  bit             m_oneshot = 0;
  bit             m_stop_latch = 0;
  int             m_burst = 0;
  int             m_cnt = 0;
  logic [NCH-1:0] m_pulse = '0;
  bit             m_cs = 0;

  int cycle_no = 0;
  int high_run0 = 0;
  int last_width0 = 0;
  int last_cs_cycle = -1;
  int last_cs_gap = 0;
  int cs_count = 0;
  bit saw_ch12 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycle_no);
    end
  endtask

  task automatic modelStep();
    int sh_start [NCH];
    int sh_stop  [NCH];
    int sh_period;
    int p;
    sh_start  = m_start_sh;
    sh_stop   = m_stop_sh;
    sh_period = m_period_sh;
    if (wr_en) begin
      if (int'(wr_addr) < 2 * NCH) begin
        if (wr_addr[0]) sh_stop[int'(wr_addr) / 2] = int'(wr_data);
        else            sh_start[int'(wr_addr) / 2] = int'(wr_data);
      end else if (int'(wr_addr) == 2 * NCH) begin
        sh_period = int'(wr_data);
      end
    end
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_start_sh[i] = 0; m_stop_sh[i] = 0; m_start_lv[i] = 0; m_stop_lv[i] = 0;
      end
      m_period_sh = DEF_PERIOD; m_period_lv = DEF_PERIOD;
      m_running = 0; m_count = 0; m_oneshot = 0; m_stop_latch = 0; m_burst = 0;
      m_cnt = 0; m_pulse = '0; m_cs = 0;
      return;
    end
    m_start_sh = sh_start; m_stop_sh = sh_stop; m_period_sh = sh_period;
    if (abort) begin
      m_running = 0; m_count = 0; m_pulse = '0; m_cs = 0; m_stop_latch = 0;
    end else if (!m_running) begin
      m_pulse = '0; m_cs = 0;
      if (run) begin
        m_running = 1; m_count = 0; m_cnt = 0;
        m_oneshot = oneshot; m_stop_latch = stop;
        m_start_lv = sh_start; m_stop_lv = sh_stop; m_period_lv = sh_period;
`ifdef POP_BURST_EN
        m_burst = int'(burst_len);
`else
        m_burst = 0;
`endif
      end
    end else begin
      p = (m_period_lv < 2) ? 2 : m_period_lv;
      m_cs = (m_count == 0);
      for (int i = 0; i < NCH; i++) m_pulse[i] = (m_start_lv[i] <= m_count) && (m_count < m_stop_lv[i]);
      if (stop) m_stop_latch = 1;
      if (m_count == p - 1) begin
        m_start_lv = sh_start; m_stop_lv = sh_stop; m_period_lv = sh_period;
        m_cnt = (m_cnt + 1) % (1 << WIDTH);
        m_count = 0;
        if (m_oneshot || m_stop_latch || (m_burst != 0 && m_cnt == m_burst)) begin
          m_running = 0; m_stop_latch = 0;
        end
      end else begin
        m_count++;
      end
    end
  endtask

  // One clock: advance the model, let the DUT take the edge, then compare and gather measurements.
  task automatic stepCycle();
    modelStep();
    @(posedge clk_2M5);
    #1;
    cycle_no++;
    checkOutput("pulse_out", 32'(pulse_out), 32'(m_pulse));
    checkOutput("cycle_start", 32'(cycle_start), 32'(m_cs));
    checkOutput("busy", 32'(busy), 32'(m_running));
    checkOutput("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    if (pulse_out[0] === 1'b1) high_run0++;
    else if (high_run0 != 0) begin last_width0 = high_run0; high_run0 = 0; end
    if (cycle_start === 1'b1) begin
      if (last_cs_cycle >= 0) last_cs_gap = cycle_no - last_cs_cycle;
      last_cs_cycle = cycle_no;
      cs_count++;
    end
    if (pulse_out[1] === 1'b1 || pulse_out[2] === 1'b1) saw_ch12 = 1;
    run = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) stepCycle();
  endtask

  task automatic writeReg(input int addr, input int data);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = WIDTH'(data);
    stepCycle();
  endtask

  task automatic waitIdle(input int budget, input string tag);
    for (int i = 0; i < budget && busy === 1'b1; i++) stepCycle();
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic resetMeasures();
    high_run0 = 0; last_width0 = 0; last_cs_cycle = -1; last_cs_gap = 0; cs_count = 0; saw_ch12 = 0;
  endtask

  initial begin
    int busy_cycles;
    int r;

    reset_n = 1'b0;
    applyStimulus(2);
    reset_n = 1'b1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pulse", 32'(pulse_out), 32'd0);
    checkOutput("reset_cnt", 32'(cycle_cnt), 32'd0);

    // Continuous run: 2000-clk pulse, 3000-clk cycle.
    writeReg(0, 10);
    writeReg(1, 2010);
    writeReg(8, 3000);
    resetMeasures();
    run = 1'b1;
    stepCycle();
    checkOutput("run_latency_cs", 32'(cycle_start), 32'd0);
    stepCycle();
    checkOutput("run_latency_cs2", 32'(cycle_start), 32'd1);
    applyStimulus(6100);
    checkOutput("t1_width", 32'(last_width0), 32'd2000);
    checkOutput("t1_period", 32'(last_cs_gap), 32'd3000);
    stop = 1'b1;
    stepCycle();
    waitIdle(3100, "t1_stop_timeout");

    // Oneshot: exactly one cycle.
    oneshot = 1'b1; run = 1'b1;
    stepCycle();
    oneshot = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4000 && busy === 1'b1; i++) begin
      stepCycle();
      if (busy === 1'b1) busy_cycles++;
    end
    checkOutput("t2_busy_len", 32'(busy_cycles), 32'd3000);
    checkOutput("t2_cycle_cnt", 32'(cycle_cnt), 32'd1);
    applyStimulus(3);
    checkOutput("t2_pulse_low", 32'(pulse_out), 32'd0);

    // Mid-cycle stop-compare write lands on the next cycle.
    resetMeasures();
    run = 1'b1;
    applyStimulus(500);
    writeReg(1, 1010);
    applyStimulus(1999);
    checkOutput("t3_width_old", 32'(last_width0), 32'd2000);
    applyStimulus(2000);
    checkOutput("t3_width_new", 32'(last_width0), 32'd1000);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;

    // Abort while channel 0 is high, then restart from count 0.
    run = 1'b1;
    applyStimulus(101);
    checkOutput("t4_pre_abort_pulse", 32'(pulse_out[0]), 32'd1);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("t4_abort_pulse", 32'(pulse_out), 32'd0);
    checkOutput("t4_abort_busy", 32'(busy), 32'd0);
    applyStimulus(3);
    run = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("t4_restart_cs", 32'(cycle_start), 32'd1);
    applyStimulus(20);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;

    // Empty windows never assert; period 1 runs as a 2-clk cycle.
    writeReg(2, 50);
    writeReg(3, 50);
    writeReg(4, 60);
    writeReg(5, 40);
    writeReg(8, 1);
    resetMeasures();
    run = 1'b1;
    applyStimulus(200);
    checkOutput("t5_empty_windows", 32'(saw_ch12), 32'd0);
    checkOutput("t5_period_min", 32'(last_cs_gap), 32'd2);
    stop = 1'b1;
    stepCycle();
    waitIdle(10, "t5_stop_timeout");

`ifdef POP_BURST_EN
    writeReg(8, 20);
    resetMeasures();
    burst_len = WIDTH'(3);
    run = 1'b1;
    stepCycle();
    waitIdle(200, "t6_burst_timeout");
    checkOutput("t6_burst_cs", 32'(cs_count), 32'd3);
    checkOutput("t6_burst_cnt", 32'(cycle_cnt), 32'd3);
    run = 1'b1;
    applyStimulus(6);
    stop = 1'b1;
    stepCycle();
    waitIdle(200, "t6_stop_timeout");
    checkOutput("t6_stop_cnt", 32'(cycle_cnt), 32'd1);
    burst_len = '0;
`endif

    // Randomized traffic against the model.
    reset_n = 1'b0;
    stepCycle();
    reset_n = 1'b1;
    for (int n = 0; n < 12000; n++) begin
      r       = $urandom_range(0, 999);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      wr_data = (int'(wr_addr) == 2 * NCH) ? WIDTH'($urandom_range(0, 24)) : WIDTH'($urandom_range(0, 30));
      run     = (r < 30);
      stop    = (r >= 25 && r < 40);
      abort   = (r >= 40 && r < 44);
      reset_n = (r != 999);
      oneshot = ($urandom_range(0, 3) == 0);
`ifdef POP_BURST_EN
      burst_len = WIDTH'($urandom_range(0, 4));
`endif
      stepCycle();
    end
    reset_n = 1'b1;
    abort = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
